// File: rtl/phy_tx_pkg.sv
// Shared types and default constants for the phy_tx lane controller.
//   - tx_state_t  : controller state encoding (RESET/ALIGN/IDLE/ACTIVE)
//   - *_DEF       : default symbol width and control symbol values
//   - max2()      : helper used to size the shared symbol counter
package phy_tx_pkg;

  localparam int         DATA_W_DEF  = 8;
  localparam logic [7:0] COM_SYM_DEF = 8'hBC;
  localparam logic [7:0] IDL_SYM_DEF = 8'h7C;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } tx_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/phy_tx_sym_cnt.sv
// Symbol counter shared by the ALIGN and IDLE phases of phy_tx_ctrl.
// Ports:
//   cclk            core clock
//   default_values  asynchronous active-high reset
//   clr             clear to zero (wins over inc)
//   inc             increment, saturating at SAT
//   limit           terminal threshold for the current phase
//   term            1 when the symbol currently on the line is the
//                   limit-th one of this phase, i.e. cnt + 1 >= limit
module phy_tx_sym_cnt #(
  parameter int CNT_W = 3,
  parameter int SAT   = 4
) (
  input  logic             cclk,
  input  logic             default_values,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic             term
);

  localparam logic [CNT_W-1:0] SAT_V = CNT_W'(SAT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge cclk or posedge default_values) begin
    if (default_values) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != SAT_V)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // The counter holds "symbols emitted in this phase minus one", so the
  // +1 converts it back to a symbol count before comparing.
  assign term = (({1'b0, cnt} + (CNT_W+1)'(1)) >= {1'b0, limit});

endmodule

// File: rtl/phy_tx_ctrl.sv
// Per-lane transmit sequencer in front of the phy_tx serializer.
// After enable it sends ALIGN_CNT COM symbols, then IDL fill; once IDLE_MIN
// IDLs are out it opens a valid/ready window and forwards data bytes.
// Every output is registered and describes the symbol launched at the
// last clock edge; state_out matches that symbol's state.
// Ports:
//   cclk            core clock
//   default_values  asynchronous active-high reset
//   enable          link enable, low returns to RESET (priority over data)
//   valid_in        upstream byte valid
//   data_in         upstream byte
//   ready_out       byte accepted at an edge where valid_in & ready_out
//   ser_valid       ser_data carries a symbol
//   ser_data        symbol to serializer
//   ser_k           1 = control symbol, 0 = data
//   state_out       current state encoding
//   byte_count      accepted-byte count (live only with PHY_TX_CTRL_CNT_EN)
// Build option: define PHY_TX_CTRL_CNT_EN to enable the saturating byte
// counter; otherwise byte_count is constant zero.
module phy_tx_ctrl
  import phy_tx_pkg::*;
#(
  parameter int                DATA_W    = DATA_W_DEF,
  parameter logic [DATA_W-1:0] COM_SYM   = DATA_W'(COM_SYM_DEF),
  parameter logic [DATA_W-1:0] IDL_SYM   = DATA_W'(IDL_SYM_DEF),
  parameter int                ALIGN_CNT = 4,
  parameter int                IDLE_MIN  = 2
) (
  input  logic              cclk,
  input  logic              default_values,
  input  logic              enable,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready_out,
  output logic              ser_valid,
  output logic [DATA_W-1:0] ser_data,
  output logic              ser_k,
  output logic [1:0]        state_out,
  output logic [15:0]       byte_count
);

  localparam int               CNT_MAX = max2(ALIGN_CNT, IDLE_MIN);
  localparam int               CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] ALIGN_LIM = CNT_W'(ALIGN_CNT);
  // ready is registered together with the next IDL, so it must rise when
  // the (IDLE_MIN-1)-th IDL is on the line and the IDLE_MIN-th is launched.
  localparam logic [CNT_W-1:0] IDLE_LIM  = CNT_W'(IDLE_MIN - 1);
  localparam logic             IDLE_FIRST_RDY = (IDLE_MIN == 1);

  tx_state_t         state_q, state_d;
  logic              cnt_clr, cnt_inc, cnt_term;
  logic [CNT_W-1:0]  cnt_limit;
  logic              sv_d, k_d, rdy_d;
  logic [DATA_W-1:0] sd_d;

  phy_tx_sym_cnt #(
    .CNT_W (CNT_W),
    .SAT   (CNT_MAX)
  ) u_sym_cnt (
    .cclk           (cclk),
    .default_values (default_values),
    .clr            (cnt_clr),
    .inc            (cnt_inc),
    .limit          (cnt_limit),
    .term           (cnt_term)
  );

  always_ff @(posedge cclk or posedge default_values) begin
    if (default_values) begin
      state_q   <= ST_RESET;
      ser_valid <= 1'b0;
      ser_data  <= '0;
      ser_k     <= 1'b0;
      ready_out <= 1'b0;
    end else begin
      state_q   <= state_d;
      ser_valid <= sv_d;
      ser_data  <= sd_d;
      ser_k     <= k_d;
      ready_out <= rdy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    cnt_limit = ALIGN_LIM;
    sv_d      = 1'b0;
    sd_d      = '0;
    k_d       = 1'b0;
    rdy_d     = 1'b0;

    case (state_q)
      ST_RESET: begin
        if (enable) begin
          state_d = ST_ALIGN;
          cnt_clr = 1'b1;
          sv_d    = 1'b1;
          sd_d    = COM_SYM;
          k_d     = 1'b1;
        end
      end

      ST_ALIGN: begin
        sv_d = 1'b1;
        k_d  = 1'b1;
        if (cnt_term) begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
          sd_d    = IDL_SYM;
          rdy_d   = IDLE_FIRST_RDY;
        end else begin
          sd_d    = COM_SYM;
          cnt_inc = 1'b1;
        end
      end

      ST_IDLE: begin
        cnt_limit = IDLE_LIM;
        sv_d      = 1'b1;
        if (ready_out && valid_in) begin
          state_d = ST_ACTIVE;
          sd_d    = data_in;
          rdy_d   = 1'b1;
        end else begin
          sd_d    = IDL_SYM;
          k_d     = 1'b1;
          cnt_inc = 1'b1;
          rdy_d   = cnt_term;
        end
      end

      ST_ACTIVE: begin
        sv_d = 1'b1;
        if (valid_in) begin
          sd_d  = data_in;
          rdy_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
          sd_d    = IDL_SYM;
          k_d     = 1'b1;
          rdy_d   = IDLE_FIRST_RDY;
        end
      end

      default: begin
        state_d = ST_RESET;
      end
    endcase

    // Link drop overrides everything, including a byte offered this cycle.
    if (!enable) begin
      state_d = ST_RESET;
      cnt_clr = 1'b1;
      sv_d    = 1'b0;
      sd_d    = '0;
      k_d     = 1'b0;
      rdy_d   = 1'b0;
    end
  end

  assign state_out = state_q;

`ifdef PHY_TX_CTRL_CNT_EN
  // ready_out is only ever high in IDLE/ACTIVE, so this is exactly the
  // accepted-transfer condition; enable low drops the byte.
  logic take;
  assign take = enable & valid_in & ready_out;

  always_ff @(posedge cclk or posedge default_values) begin
    if (default_values) begin
      byte_count <= '0;
    end else if (take && (byte_count != 16'hFFFF)) begin
      byte_count <= byte_count + 16'd1;
    end
  end
`else
  assign byte_count = 16'h0000;
`endif

endmodule

// File: tb/tb_phy_tx_ctrl.sv
module tb_phy_tx_ctrl;

  logic        cclk = 1'b0;
  logic        default_values;
  logic        enable;
  logic        valid_in;
  logic [7:0]  data_in;
  logic        ready_out;
  logic        ser_valid;
  logic [7:0]  ser_data;
  logic        ser_k;
  logic [1:0]  state_out;
  logic [15:0] byte_count;

  int checks   = 0;
  int failures = 0;

  phy_tx_ctrl dut (
    .cclk           (cclk),
    .default_values (default_values),
    .enable         (enable),
    .valid_in       (valid_in),
    .data_in        (data_in),
    .ready_out      (ready_out),
    .ser_valid      (ser_valid),
    .ser_data       (ser_data),
    .ser_k          (ser_k),
    .state_out      (state_out),
    .byte_count     (byte_count)
  );

  always #5 cclk = ~cclk;

  typedef struct {
    logic        en;
    logic        vld;
    logic [7:0]  din;
    logic        sv;
    logic [7:0]  sd;
    logic        k;
    logic        rdy;
    logic [1:0]  st;
    logic [15:0] cnt;
  } vec_t;

  localparam int NV = 28;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge cclk);
    #1;
  endtask

  function automatic logic [15:0] exp_bc(input logic [15:0] c);
`ifdef PHY_TX_CTRL_CNT_EN
    return c;
`else
    return (c & 16'h0000);
`endif
  endfunction

  task automatic chk_all(input string tag, input logic sv, input logic [7:0] sd,
                         input logic k, input logic rdy, input logic [1:0] st,
                         input logic [15:0] cnt);
    chk({tag, " ser_valid"}, 32'(ser_valid), 32'(sv));
    if (sv) chk({tag, " ser_data"}, 32'(ser_data), 32'(sd));
    chk({tag, " ser_k"}, 32'(ser_k), 32'(k));
    chk({tag, " ready_out"}, 32'(ready_out), 32'(rdy));
    chk({tag, " state_out"}, 32'(state_out), 32'(st));
    chk({tag, " byte_count"}, 32'(byte_count), 32'(exp_bc(cnt)));
  endtask

  initial begin
    //            en    vld   din    sv    sd     k     rdy   st     cnt
    tbl[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 16'd0};
    tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 16'd0};
    // bring-up with an early valid byte AA held by upstream
    tbl[2]  = '{1'b1, 1'b1, 8'hAA, 1'b1, 8'hBC, 1'b1, 1'b0, 2'd1, 16'd0};
    tbl[3]  = '{1'b1, 1'b1, 8'hAA, 1'b1, 8'hBC, 1'b1, 1'b0, 2'd1, 16'd0};
    tbl[4]  = '{1'b1, 1'b1, 8'hAA, 1'b1, 8'hBC, 1'b1, 1'b0, 2'd1, 16'd0};
    tbl[5]  = '{1'b1, 1'b1, 8'hAA, 1'b1, 8'hBC, 1'b1, 1'b0, 2'd1, 16'd0};
    tbl[6]  = '{1'b1, 1'b1, 8'hAA, 1'b1, 8'h7C, 1'b1, 1'b0, 2'd2, 16'd0};
    tbl[7]  = '{1'b1, 1'b1, 8'hAA, 1'b1, 8'h7C, 1'b1, 1'b1, 2'd2, 16'd0};
    tbl[8]  = '{1'b1, 1'b1, 8'hAA, 1'b1, 8'hAA, 1'b0, 1'b1, 2'd3, 16'd1};
    tbl[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h7C, 1'b1, 1'b0, 2'd2, 16'd1};
    // burst FF DD EE CC; FF offered while ready is still low is not taken
    tbl[10] = '{1'b1, 1'b1, 8'hFF, 1'b1, 8'h7C, 1'b1, 1'b1, 2'd2, 16'd1};
    tbl[11] = '{1'b1, 1'b1, 8'hFF, 1'b1, 8'hFF, 1'b0, 1'b1, 2'd3, 16'd2};
    tbl[12] = '{1'b1, 1'b1, 8'hDD, 1'b1, 8'hDD, 1'b0, 1'b1, 2'd3, 16'd3};
    tbl[13] = '{1'b1, 1'b1, 8'hEE, 1'b1, 8'hEE, 1'b0, 1'b1, 2'd3, 16'd4};
    tbl[14] = '{1'b1, 1'b1, 8'hCC, 1'b1, 8'hCC, 1'b0, 1'b1, 2'd3, 16'd5};
    tbl[15] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h7C, 1'b1, 1'b0, 2'd2, 16'd5};
    tbl[16] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h7C, 1'b1, 1'b1, 2'd2, 16'd5};
    tbl[17] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h7C, 1'b1, 1'b1, 2'd2, 16'd5};
    // raw data equal to control symbols stays data
    tbl[18] = '{1'b1, 1'b1, 8'hBC, 1'b1, 8'hBC, 1'b0, 1'b1, 2'd3, 16'd6};
    tbl[19] = '{1'b1, 1'b1, 8'h7C, 1'b1, 8'h7C, 1'b0, 1'b1, 2'd3, 16'd7};
    // enable drop mid-burst: 55 dropped, not counted
    tbl[20] = '{1'b0, 1'b1, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 16'd7};
    tbl[21] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 16'd7};
    // re-enable repeats full alignment
    tbl[22] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'hBC, 1'b1, 1'b0, 2'd1, 16'd7};
    tbl[23] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'hBC, 1'b1, 1'b0, 2'd1, 16'd7};
    tbl[24] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'hBC, 1'b1, 1'b0, 2'd1, 16'd7};
    tbl[25] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'hBC, 1'b1, 1'b0, 2'd1, 16'd7};
    tbl[26] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h7C, 1'b1, 1'b0, 2'd2, 16'd7};
    tbl[27] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h7C, 1'b1, 1'b1, 2'd2, 16'd7};

    default_values = 1'b1;
    enable         = 1'b0;
    valid_in       = 1'b0;
    data_in        = 8'h00;
    step();
    step();
    chk_all("reset", 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 16'd0);
    chk("reset ser_data", 32'(ser_data), 32'h0);
    default_values = 1'b0;

    for (int i = 0; i < NV; i++) begin
      enable   = tbl[i].en;
      valid_in = tbl[i].vld;
      data_in  = tbl[i].din;
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].sv, tbl[i].sd, tbl[i].k,
              tbl[i].rdy, tbl[i].st, tbl[i].cnt);
    end

    // Asynchronous reset in the middle of ALIGN
    enable   = 1'b0;
    valid_in = 1'b0;
    step();
    chk("drop state_out", 32'(state_out), 32'd0);
    enable = 1'b1;
    step();
    chk("realign0 ser_data", 32'(ser_data), 32'hBC);
    step();
    chk("realign1 state_out", 32'(state_out), 32'd1);
    #3;
    default_values = 1'b1;
    #1;
    chk_all("async", 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 16'd0);
    chk("async ser_data", 32'(ser_data), 32'h0);
    chk("async byte_count", 32'(byte_count), 32'h0);
    #1;
    default_values = 1'b0;
    for (int j = 0; j < 4; j++) begin
      step();
      chk_all($sformatf("post_async_com%0d", j), 1'b1, 8'hBC, 1'b1, 1'b0, 2'd1, 16'd0);
    end
    step();
    chk_all("post_async_idl0", 1'b1, 8'h7C, 1'b1, 1'b0, 2'd2, 16'd0);
    step();
    chk_all("post_async_idl1", 1'b1, 8'h7C, 1'b1, 1'b1, 2'd2, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
